conv_acc_sequencer: RTL and testbench

Job sequencer for the memory-mapped convolution accelerator. The CPU works through a small control window on the external bus: it pushes input words into a local buffer, then issues GO. The block then drives the accelerator port autonomously: load data, start, poll for completion, capture the result. The CPU never has to busy-wait on the accelerator. It sits between the CPU external-bus address decode and the accelerator's addr/en/we/din/dout port, and is the only master of that port.

---
 rtl/conv_acc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_conv_acc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_sequencer.sv
// Job sequencer for the convolution accelerator: buffers CPU words, then loads them,
// starts the accelerator, polls for done and captures the result on its own.
module conv_acc_sequencer #(
  parameter int unsigned DEPTH           = 16,
  parameter logic [5:0]  ACC_DATA_BASE   = 6'd0,
  parameter logic [5:0]  ACC_CTRL_ADDR   = 6'd32,
  parameter logic [5:0]  ACC_STATUS_ADDR = 6'd33,
  parameter logic [5:0]  ACC_RESULT_ADDR = 6'd34,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [5:0]  cpu_addr,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        acc_en,
  output logic        acc_we,
  output logic [5:0]  acc_addr,
  output logic [31:0] acc_din,
  input  logic [31:0] acc_dout,
  output logic        busy
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PollLast = PW'(TIMEOUT - 1);
  localparam logic [5:0] DepthMax = 6'(DEPTH);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StPollReq, StPollWait, StResReq, StResWait
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    i_q, i_d;
  logic [5:0]    count_q, count_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   result_q, result_d;
  logic [31:0]   cpu_dout_q, cpu_dout_d;
  logic [31:0]   data_buf_q [DEPTH];
  logic [31:0]   rd_data;

  logic cpu_wr, cpu_rd, ctrl_wr, go, abort, clr, push, push_ok;

  assign cpu_wr  = cpu_en & cpu_we;
  assign cpu_rd  = cpu_en & ~cpu_we;
  assign ctrl_wr = cpu_wr & (cpu_addr == 6'd0);
  assign go      = ctrl_wr & cpu_din[0];
  assign abort   = ctrl_wr & cpu_din[1];
  assign clr     = ctrl_wr & cpu_din[2];
  assign push    = cpu_wr & (cpu_addr == 6'd3);
  assign push_ok = push & (state_q == StIdle) & (count_q < DepthMax);

  assign busy     = (state_q != StIdle);
  assign cpu_dout = cpu_dout_q;

  always_comb begin
    rd_data = '0;
    case (cpu_addr)
      6'd1:    rd_data = {22'd0, count_q, ovf_q, err_q, done_q, busy};
      6'd2:    rd_data = result_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    count_d    = count_q;
    poll_d     = poll_q;
    done_d     = done_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    cpu_dout_d = cpu_rd ? rd_data : cpu_dout_q;
    acc_en     = 1'b0;
    acc_we     = 1'b0;
    acc_addr   = '0;
    acc_din    = '0;

    if (clr) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
    end
    if (push) begin
      if (push_ok) count_d = count_q + 6'd1;
      else         ovf_d   = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // ABORT in the same write beats GO and must leave done/err alone.
        if (go && !abort) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          i_d     = '0;
          state_d = (count_q != 6'd0) ? StLoad : StStart;
        end
      end
      StLoad: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ACC_DATA_BASE + i_q;
        acc_din  = data_buf_q[i_q[IW-1:0]];
        if (i_q == count_q - 6'd1) state_d = StStart;
        else                       i_d     = i_q + 6'd1;
      end
      StStart: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = ACC_CTRL_ADDR;
        acc_din  = 32'd1;
        poll_d   = '0;
        state_d  = StPollReq;
      end
      StPollReq: begin
        acc_en   = 1'b1;
        acc_addr = ACC_STATUS_ADDR;
        state_d  = StPollWait;
      end
      StPollWait: begin
        if (acc_dout[0]) begin
          state_d = StResReq;
        end else if (poll_q == PollLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          poll_d  = poll_q + 1'b1;
          state_d = StPollReq;
        end
      end
      StResReq: begin
        acc_en   = 1'b1;
        acc_addr = ACC_RESULT_ADDR;
        state_d  = StResWait;
      end
      StResWait: begin
        result_d = acc_dout;
        done_d   = 1'b1;
        count_d  = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      count_q    <= '0;
      poll_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      cpu_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      count_q    <= count_d;
      poll_q     <= poll_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  // Buffer storage needs no reset; only count_q decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) data_buf_q[count_q[IW-1:0]] <= cpu_din;
  end

endmodule

// File: tb/tb_conv_acc_sequencer.sv
// Directed bench for conv_acc_sequencer with a small behavioural accelerator model.
module tb_conv_acc_sequencer;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        acc_en;
  logic        acc_we;
  logic [5:0]  acc_addr;
  logic [31:0] acc_din;
  logic [31:0] acc_dout;
  logic        busy;

  conv_acc_sequencer #(
    .DEPTH   (16),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_en   (cpu_en),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .acc_en   (acc_en),
    .acc_we   (acc_we),
    .acc_addr (acc_addr),
    .acc_din  (acc_din),
    .acc_dout (acc_dout),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Accelerator model and bus monitor
  int          done_on;
  logic [31:0] res_val;
  int          polls;
  int          n_data, n_ctrl, n_stat, en_cnt, busy_cyc, cyc;
  int          first_cyc, last_cyc;
  logic [5:0]  d_addr [64];
  logic [31:0] d_data [64];
  logic [31:0] ctrl_din;

  initial begin
    acc_dout = '0;
    done_on  = 0;
    res_val  = '0;
    polls    = 0;
    cyc      = 0;
  end

  always @(posedge clk) begin
    if (acc_en) en_cnt++;
    if (acc_en && acc_we && acc_addr < 6'd32) begin
      if (n_data < 64) begin
        d_addr[n_data] = acc_addr;
        d_data[n_data] = acc_din;
      end
      if (n_data == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_data++;
    end
    if (acc_en && acc_we && acc_addr == 6'd32) begin
      n_ctrl++;
      ctrl_din = acc_din;
      polls    = 0;
    end
    if (acc_en && !acc_we && acc_addr == 6'd33) begin
      polls++;
      n_stat++;
      acc_dout <= {31'd0, (done_on != 0) && (polls >= done_on)};
    end
    if (acc_en && !acc_we && acc_addr == 6'd34) acc_dout <= res_val;
    if (busy) busy_cyc++;
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_mon();
    n_data = 0; n_ctrl = 0; n_stat = 0; en_cnt = 0; busy_cyc = 0;
    first_cyc = 0; last_cyc = 0; ctrl_din = '0;
  endtask

  task automatic cpu_wr(input logic [5:0] a, input logic [31:0] d);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    cpu_en = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [5:0] a, output logic [31:0] d);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    d = cpu_dout;
    cpu_en = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) cpu_wr(6'd3, base + 32'(k));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        any_en;
    int          n;
    reset_mon();
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_acc_we", {31'd0, acc_we}, 32'd0);
    check_eq("rst_acc_addr", {26'd0, acc_addr}, 32'd0);
    check_eq("rst_acc_din", acc_din, 32'd0);
    check_eq("rst_cpu_dout", cpu_dout, 32'd0);
    rst = 1'b0;
    any_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any_en |= acc_en;
    end
    check_eq("rst_acc_en_10", {31'd0, any_en}, 32'd0);
    cpu_rd(6'd1, rd); check_eq("rst_status", rd, 32'h0);
    cpu_rd(6'd2, rd); check_eq("rst_result", rd, 32'h0);

    // Nine-word job, done on third poll
    push_words(32'h11, 9);
    done_on = 3; res_val = 32'hCAFE;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    check_eq("go_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check_eq("j1_nwr", n_data, 9);
    for (int k = 0; k < 9; k++) begin
      check_eq("j1_addr", {26'd0, d_addr[k]}, 32'(k));
      check_eq("j1_data", d_data[k], 32'h11 + 32'(k));
    end
    check_eq("j1_consec", last_cyc - first_cyc, 8);
    check_eq("j1_nctrl", n_ctrl, 1);
    check_eq("j1_ctrl_din", ctrl_din, 32'd1);
    check_eq("j1_nstat", n_stat, 3);
    check_eq("j1_busy_cyc", busy_cyc, 18);
    cpu_rd(6'd2, rd); check_eq("j1_result", rd, 32'hCAFE);
    cpu_rd(6'd1, rd); check_eq("j1_status", rd, 32'h002);
    cpu_rd(6'd7, rd); check_eq("unmapped_rd", rd, 32'h0);

    // Overflow: 17 pushes into a 16-deep buffer
    cpu_wr(6'd0, 32'h4);
    push_words(32'h100, 17);
    cpu_rd(6'd1, rd); check_eq("ovf_status", rd, 32'h108);
    done_on = 1; res_val = 32'h1234;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    wait_idle();
    check_eq("ovf_nwr", n_data, 16);
    check_eq("ovf_first", d_data[0], 32'h100);
    check_eq("ovf_last", d_data[15], 32'h10F);
    cpu_rd(6'd1, rd); check_eq("ovf_done_status", rd, 32'h00A);
    cpu_wr(6'd0, 32'h4);
    cpu_rd(6'd1, rd); check_eq("clr_status", rd, 32'h000);

    // Timeout with preserved count, then retry
    push_words(32'h21, 3);
    done_on = 0;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    wait_idle();
    check_eq("to_nstat", n_stat, 8);
    cpu_rd(6'd1, rd); check_eq("to_status", rd, 32'h034);
    done_on = 1; res_val = 32'h77;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    wait_idle();
    check_eq("retry_nwr", n_data, 3);
    check_eq("retry_last", d_data[2], 32'h23);
    cpu_rd(6'd1, rd); check_eq("retry_status", rd, 32'h002);
    cpu_rd(6'd2, rd); check_eq("retry_result", rd, 32'h77);

    // Abort after four of ten loads; GO and PUSH while busy
    push_words(32'h40, 10);
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    cpu_wr(6'd0, 32'h1);
    cpu_wr(6'd3, 32'hDEAD);
    @(negedge clk);
    cpu_wr(6'd0, 32'h2);
    repeat (10) @(negedge clk);
    check_eq("ab_nwr", n_data, 4);
    check_eq("ab_en_cnt", en_cnt, 4);
    check_eq("ab_addr3", {26'd0, d_addr[3]}, 32'd3);
    check_eq("ab_data3", d_data[3], 32'h43);
    check_eq("ab_busy", {31'd0, busy}, 32'd0);
    cpu_rd(6'd1, rd); check_eq("ab_status", rd, 32'h008);
    cpu_wr(6'd0, 32'h4);
    cpu_rd(6'd1, rd); check_eq("ab_clr_status", rd, 32'h000);

    // Reset in POLL_WAIT, then a fresh job
    push_words(32'h60, 2);
    done_on = 0;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    n = 0;
    while (n_stat == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("pw_reached", n_stat, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("pw_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("pw_rst_en", {31'd0, acc_en}, 32'd0);
    check_eq("pw_rst_we", {31'd0, acc_we}, 32'd0);
    check_eq("pw_rst_addr", {26'd0, acc_addr}, 32'd0);
    check_eq("pw_rst_din", acc_din, 32'd0);
    rst = 1'b0;
    cpu_rd(6'd1, rd); check_eq("pw_rst_status", rd, 32'h000);
    cpu_rd(6'd2, rd); check_eq("pw_rst_result", rd, 32'h0);
    push_words(32'h55, 1);
    done_on = 2; res_val = 32'hBEEF;
    reset_mon();
    cpu_wr(6'd0, 32'h1);
    wait_idle();
    check_eq("post_nwr", n_data, 1);
    check_eq("post_nstat", n_stat, 2);
    cpu_rd(6'd2, rd); check_eq("post_result", rd, 32'hBEEF);
    cpu_rd(6'd1, rd); check_eq("post_status", rd, 32'h002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
